mul_sequencer: RTL and testbench

Multi-cycle shift-add multiply sequencer for the MUL/MULS family (MULI, MULR, MULSI, MULSR) beside the single-cycle execute stage.
- Captures operands on start and stalls the front end while running.
- Iterates one multiplier bit per cycle.
- Returns a register writeback plus, for MULS variants, an NZCV flag update.
- Execute-stage flag register takes flags_out when flags_write is high; register file takes write_data when write_to_reg is high.

---
 rtl/mul_pkg.sv | 22 ++
 rtl/mul_if.sv | 29 ++
 rtl/mul_flag_gen.sv | 23 ++
 rtl/mul_sequencer.sv | 130 +++++++++++++
 tb/tb_mul_sequencer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiply sequencer and its flag generator.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_e;

  localparam logic [1:0] MUL_I  = 2'b00;
  localparam logic [1:0] MUL_R  = 2'b01;
  localparam logic [1:0] MULS_I = 2'b10;
  localparam logic [1:0] MULS_R = 2'b11;

  // Bit positions inside the NZCV nibble
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/mul_if.sv
// Request/writeback bundle between the execute stage and the multiply sequencer.
interface mul_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       mul_type;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [3:0]       dest_reg;
  logic             abort;
  logic             busy;
  logic             stall;
  logic             done;
  logic             write_to_reg;
  logic [3:0]       write_reg;
  logic [WIDTH-1:0] write_data;
  logic             flags_write;
  logic [3:0]       flags_out;

  modport master (
    output start, mul_type, operand_a, operand_b, dest_reg, abort,
    input  busy, stall, done, write_to_reg, write_reg, write_data, flags_write, flags_out
  );

  modport slave (
    input  start, mul_type, operand_a, operand_b, dest_reg, abort,
    output busy, stall, done, write_to_reg, write_reg, write_data, flags_write, flags_out
  );
endinterface

// File: rtl/mul_flag_gen.sv
// Combinational NZCV generation from a double-width product; C is always 0.
module mul_flag_gen
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] prod,
  output logic [3:0]         flags
);

  logic [WIDTH:0] upper;

  // Overflow when the bits above the result sign are not a pure sign extension
  always_comb begin
    upper         = prod[2*WIDTH-1:WIDTH-1];
    flags         = 4'b0000;
    flags[FLAG_N] = prod[WIDTH-1];
    flags[FLAG_Z] = (prod[WIDTH-1:0] == '0);
    flags[FLAG_C] = 1'b0;
    flags[FLAG_V] = !((&upper) || !(|upper));
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add multiplier for MULI/MULR/MULSI/MULSR.
// Optional macro MUL_EARLY_TERM_EN: leave ITER once the remaining multiplier is zero.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// ITER  | one multiplier bit per cycle into the accumulator
// FIX   | apply sign, register result and flags
// DONE  | one-cycle writeback pulse
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst_n,
  mul_if.slave bus
);

  mul_state_e         state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     mcand, mplier;
  logic               neg, flag_op;
  logic [3:0]         dest;
  logic [WIDTH-1:0]   result;
  logic [3:0]         flags, flags_nxt;

  logic               start_ok, is_signed, iter_last;
  logic [WIDTH:0]     a_ext, b_ext, mag_a, mag_b;
  logic [2*WIDTH-1:0] partial, prod;

  assign start_ok  = (state == IDLE) && bus.start && !bus.abort;
  assign is_signed = (bus.mul_type == MULS_I) || (bus.mul_type == MULS_R);

`ifdef MUL_EARLY_TERM_EN
  assign iter_last = (mplier[WIDTH:1] == '0);
`else
  assign iter_last = (count == CNT_W'(WIDTH-1));
`endif

  // Operand magnitudes (one extra bit so the most-negative value survives) and signed product
  always_comb begin
    a_ext   = {bus.operand_a[WIDTH-1], bus.operand_a};
    b_ext   = {bus.operand_b[WIDTH-1], bus.operand_b};
    mag_a   = a_ext[WIDTH] ? -a_ext : a_ext;
    mag_b   = b_ext[WIDTH] ? -b_ext : b_ext;
    partial = {{(WIDTH-1){1'b0}}, mcand} << count;
    prod    = neg ? -acc : acc;
  end

  mul_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .prod  (prod),
    .flags (flags_nxt)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort returns to IDLE from any active state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_ok) state_nxt = ITER;
      ITER: begin
        if (bus.abort)     state_nxt = IDLE;
        else if (iter_last) state_nxt = FIX;
      end
      FIX:  state_nxt = bus.abort ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, shift-add iteration and result registration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
      flag_op <= 1'b0;
      dest    <= '0;
      result  <= '0;
      flags   <= '0;
    end else begin
      case (state)
        IDLE: if (start_ok) begin
          dest    <= bus.dest_reg;
          flag_op <= is_signed;
          acc     <= '0;
          count   <= '0;
          if (is_signed) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            neg    <= bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
          end else begin
            mcand  <= {1'b0, bus.operand_a};
            mplier <= {1'b0, bus.operand_b};
            neg    <= 1'b0;
          end
        end
        ITER: begin
          if (mplier[0]) acc <= acc + partial;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
        end
        FIX: if (!bus.abort) begin
          result <= prod[WIDTH-1:0];
          if (flag_op) flags <= flags_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.stall        = bus.busy || start_ok;
  assign bus.done         = (state == DONE);
  assign bus.write_to_reg = bus.done && !bus.abort;
  assign bus.flags_write  = bus.done && flag_op && !bus.abort;
  assign bus.write_reg    = dest;
  assign bus.write_data   = result;
  assign bus.flags_out    = flags;

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: random and directed multiplies against an arithmetic model.
module tb_mul_sequencer;
  import mul_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  typedef struct {
    logic [W-1:0] data;
    logic [3:0]   rd;
    logic [3:0]   flags;
    bit           fw;
    bit           wr;
    int           done_cyc;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] model_flags = 4'h0;

  mul_if #(.WIDTH(W)) bus ();

  mul_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("write_data",   bus.write_data,   e.data);
        chk("write_reg",    bus.write_reg,    e.rd);
        chk("flags_out",    bus.flags_out,    e.flags);
        chk("flags_write",  bus.flags_write,  e.fw);
        chk("write_to_reg", bus.write_to_reg, e.wr);
        chk("done_cycle",   cyc,              e.done_cyc);
      end
    end
  end

  // Reference: full-precision arithmetic product, flags from the numeric value
  task automatic model(input logic [1:0] t, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] data, output bit fw, output int lat);
    longint       sa, sb, sp;
    logic [63:0]  p;
    logic [W-1:0] m;
    int           iters;
    fw = t[1];
    if (fw) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sp = sa * sb;
      p  = sp;
      data = p[W-1:0];
      model_flags[FLAG_N] = data[W-1];
      model_flags[FLAG_Z] = (data == 0);
      model_flags[FLAG_C] = 1'b0;
      model_flags[FLAG_V] = (sp < -(64'sd1 <<< (W-1))) || (sp > ((64'sd1 <<< (W-1)) - 1));
      m = (sb < 0) ? W'(-sb) : W'(sb);
    end else begin
      p = {32'h0, a} * {32'h0, b};
      data = p[W-1:0];
      m = b;
    end
`ifdef MUL_EARLY_TERM_EN
    iters = 1;
    for (int i = 0; i < W; i++) if (m[i]) iters = i + 1;
`else
    iters = W;
    if (m == 0) iters = W;
`endif
    lat = iters + 2;
  endtask

  task automatic issue(input logic [1:0] t, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] d, input bit expect_wr, output int lat);
    exp_t e;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mul_type = t; bus.operand_a = a; bus.operand_b = b; bus.dest_reg = d;
    model(t, a, b, e.data, e.fw, lat);
    e.rd = d;
    e.flags = model_flags;
    e.wr = expect_wr;
    if (!expect_wr) e.fw = 1'b0;
    e.done_cyc = cyc + lat;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.operand_a = $urandom; bus.operand_b = $urandom; bus.dest_reg = 4'($urandom);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy && sb_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("idle_timeout", 64'd1, 64'd0);
      sb_q.delete();
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      4: return W'($urandom_range(0, 255));
      5: return -W'($urandom_range(1, 300));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    bus.start = 1'b0; bus.abort = 1'b0; bus.mul_type = 2'b00;
    bus.operand_a = '0; bus.operand_b = '0; bus.dest_reg = '0;
    #12;
    chk("rst_busy",       bus.busy,       0);
    chk("rst_stall",      bus.stall,      0);
    chk("rst_done",       bus.done,       0);
    chk("rst_write_data", bus.write_data, 0);
    chk("rst_flags_out",  bus.flags_out,  0);
    chk("rst_write_reg",  bus.write_reg,  0);
    @(posedge clk); #2; rst_n = 1'b1;

    issue(MUL_R,  32'd6, 32'd7, 4'd3, 1'b1, lat);           wait_idle();
    issue(MULS_I, -32'sd3, 32'd5, 4'd4, 1'b1, lat);         wait_idle();
    issue(MULS_R, 32'h0001_0000, 32'h0001_0000, 4'd5, 1'b1, lat); wait_idle();
    issue(MULS_R, 32'h8000_0000, 32'd1, 4'd6, 1'b1, lat);   wait_idle();
    issue(MULS_I, 32'd5, 32'd3, 4'd7, 1'b1, lat);           wait_idle();
    issue(MUL_I,  32'h8000_0000, 32'h8000_0000, 4'd8, 1'b1, lat); wait_idle();

    // Second start mid-operation is ignored; stall covers the whole op
    @(posedge clk); #1;
    begin
      exp_t e;
      bus.start = 1'b1; bus.mul_type = MUL_R; bus.operand_a = 32'd9; bus.operand_b = 32'd9; bus.dest_reg = 4'd9;
      model(MUL_R, 32'd9, 32'd9, e.data, e.fw, lat);
      e.rd = 4'd9; e.flags = model_flags; e.wr = 1'b1; e.done_cyc = cyc + lat;
      sb_q.push_back(e);
      for (int k = 0; k <= lat + 1; k++) begin
        @(negedge clk);
        chk("stall_window", bus.stall, (k <= lat) ? 1 : 0);
        @(posedge clk); #1;
        bus.start = (k + 1 == 10);
        bus.operand_a = 32'd1; bus.operand_b = 32'd1; bus.dest_reg = 4'd1;
      end
      bus.start = 1'b0;
    end
    wait_idle();

    // Abort mid-ITER: no writeback, then a fresh op proceeds normally
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mul_type = MUL_R; bus.operand_a = 32'd77; bus.operand_b = 32'hFFFF_FFFF;
    repeat (20) @(posedge clk);
    #1; bus.start = 1'b0; bus.abort = 1'b1;
    @(negedge clk);
    chk("abort_wr_suppressed", bus.write_to_reg, 0);
    @(posedge clk); #1; bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_to_idle", bus.busy, 0);
    issue(MUL_R, 32'd2, 32'd3, 4'd2, 1'b1, lat); wait_idle();

    // Abort with start in IDLE drops the start
    @(posedge clk); #1; bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_idle_start_dropped", bus.busy, 0);

    // Abort during DONE: result registers update, both writes suppressed
    issue(MULS_R, -32'sd7, 32'd6, 4'd10, 1'b0, lat);
    repeat (lat - 1) @(posedge clk);
    #1; bus.abort = 1'b1;
    @(posedge clk); #1; bus.abort = 1'b0;
    wait_idle();

    // Async reset mid-op clears everything without a clock edge
    issue(MULS_R, 32'd1234, -32'sd99, 4'd11, 1'b1, lat);
    repeat (13) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    chk("arst_busy",         bus.busy,         0);
    chk("arst_stall",        bus.stall,        0);
    chk("arst_done",         bus.done,         0);
    chk("arst_write_to_reg", bus.write_to_reg, 0);
    chk("arst_flags_write",  bus.flags_write,  0);
    chk("arst_write_reg",    bus.write_reg,    0);
    chk("arst_write_data",   bus.write_data,   0);
    chk("arst_flags_out",    bus.flags_out,    0);
    sb_q.delete();
    model_flags = 4'h0;
    @(posedge clk); #2; rst_n = 1'b1;

    for (int n = 0; n < 40; n++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick(), 4'($urandom), 1'b1, lat);
      wait_idle();
    end

    wait_idle();
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
